// File: rtl/block_extract_lock_if.sv
// Bus between the gearbox/seeker front end and the block extract/lock stage.
// Carries the buffer view, the seeker result, and the extracted block and lock status.
// No handshake of its own: buffer_dv qualifies inputs, data_valid_o qualifies outputs.
interface block_extract_lock_if;
  logic [193:0] gbox_buffer;
  logic [5:0]   gbox_cnt;
  logic         buffer_dv;
  logic         is_synced;
  logic [6:0]   offset_pos;
  logic [63:0]  data_o;
  logic [1:0]   hdr_o;
  logic         data_valid_o;
  logic         locked_o;
  logic [6:0]   lock_offset_o;
  logic         hdr_err_o;
  logic         realign_o;

  modport slave (
    input  gbox_buffer, gbox_cnt, buffer_dv, is_synced, offset_pos,
    output data_o, hdr_o, data_valid_o, locked_o, lock_offset_o, hdr_err_o, realign_o
  );

  modport master (
    output gbox_buffer, gbox_cnt, buffer_dv, is_synced, offset_pos,
    input  data_o, hdr_o, data_valid_o, locked_o, lock_offset_o, hdr_err_o, realign_o
  );
endinterface

// File: rtl/block_extract_lock.sv
// Latches the seeker offset, verifies sync headers there, then extracts aligned 66-bit blocks.
// Latency: all outputs registered, 1 cycle after the sampled buffer_dv.
// No backpressure: one block per buffer_dv; cycles without buffer_dv hold all state.
module block_extract_lock #(
  parameter int LOCK_GOOD = 16,
  parameter int ERR_MAX   = 8,
  parameter int WIN_LEN   = 64,
  parameter int MAX_POS   = 65
) (
  input logic             clk_i,
  input logic             rst_i,
  block_extract_lock_if.slave bus
);
  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int EW = $clog2(ERR_MAX + 1);
  localparam int WW = $clog2(WIN_LEN + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   good_q, good_d, good_inc;
  logic [EW-1:0]   errs_q, errs_d, errs_next;
  logic [WW-1:0]   win_q, win_d;
  logic [6:0]      off_q, off_d;
  logic [63:0]     data_q, data_d;
  logic [1:0]      hdr_q, hdr_d;
  logic            valid_q, valid_d;
  logic            herr_q, herr_d;
  logic            realign_q, realign_d;
  logic            locked_q, locked_d;

  // Window into the buffer: base never exceeds 128, so base+65 stays inside bit 193.
  logic [7:0]      base;
  logic [65:0]     blk;
  logic            hdr_good;

  assign base      = {1'b0, off_q} + {2'b00, bus.gbox_cnt};
  assign blk       = 66'(bus.gbox_buffer >> base);
  assign hdr_good  = (blk[65:64] == 2'b01) || (blk[65:64] == 2'b10);
  assign good_inc  = good_q + GW'(1);
  assign errs_next = hdr_good ? errs_q : errs_q + EW'(1);

  // Next-state and next-output decode; only a buffer_dv cycle can change anything.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    errs_d    = errs_q;
    win_d     = win_q;
    off_d     = off_q;
    data_d    = data_q;
    hdr_d     = hdr_q;
    valid_d   = 1'b0;
    herr_d    = 1'b0;
    realign_d = 1'b0;
    if (bus.buffer_dv) begin
      case (state_q)
        HUNT: begin
          if (bus.is_synced && (bus.offset_pos <= 7'(MAX_POS))) begin
            off_d   = bus.offset_pos;
            good_d  = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hdr_good) begin
            good_d = good_inc;
            if (good_inc == GW'(LOCK_GOOD)) begin
              state_d = LOCKED;
              errs_d  = '0;
              win_d   = '0;
            end
          end else begin
            herr_d    = 1'b1;
            realign_d = 1'b1;
            state_d   = HUNT;
          end
        end
        LOCKED: begin
          valid_d = 1'b1;
          data_d  = blk[63:0];
          hdr_d   = blk[65:64];
          herr_d  = !hdr_good;
          // The error is charged to the window it arrived in before any window reset.
          if (errs_next == EW'(ERR_MAX)) begin
            realign_d = 1'b1;
            state_d   = HUNT;
            errs_d    = '0;
            win_d     = '0;
          end else if (win_q == WW'(WIN_LEN - 1)) begin
            errs_d = '0;
            win_d  = '0;
          end else begin
            errs_d = errs_next;
            win_d  = win_q + WW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // State, counters and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= HUNT;
      good_q    <= '0;
      errs_q    <= '0;
      win_q     <= '0;
      off_q     <= '0;
      data_q    <= '0;
      hdr_q     <= '0;
      valid_q   <= 1'b0;
      herr_q    <= 1'b0;
      realign_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      errs_q    <= errs_d;
      win_q     <= win_d;
      off_q     <= off_d;
      data_q    <= data_d;
      hdr_q     <= hdr_d;
      valid_q   <= valid_d;
      herr_q    <= herr_d;
      realign_q <= realign_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.data_o        = data_q;
  assign bus.hdr_o         = hdr_q;
  assign bus.data_valid_o  = valid_q;
  assign bus.locked_o      = locked_q;
  assign bus.lock_offset_o = off_q;
  assign bus.hdr_err_o     = herr_q;
  assign bus.realign_o     = realign_q;
endmodule

// File: tb/tb_block_extract_lock.sv
// Randomized bench for block_extract_lock with a behavioural model and event scoreboard.
// Stimulus predicts output events into a queue; a negedge monitor pops and compares them.
// Lock status and offset are compared every cycle against the model.
module tb_block_extract_lock;
  localparam int LOCK_GOOD = 16;
  localparam int ERR_MAX   = 8;
  localparam int WIN_LEN   = 64;
  localparam int MAX_POS   = 65;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  block_extract_lock_if bus();

  block_extract_lock dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic        herr;
    logic        realign;
    logic        locked;
    logic [6:0]  off;
    logic [63:0] data;
    logic [1:0]  hdr;
  } ev_t;

  ev_t evq[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Reference model: 0 = hunting, 1 = verifying, 2 = locked.
  int m_mode = 0, m_good = 0, m_errs = 0, m_blk = 0, m_off = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit dv, input bit syn, input int pos,
                            input logic [193:0] b, input int cnt);
    ev_t e;
    bit emit;
    int base;
    logic [1:0]  h;
    logic [63:0] d;
    bit good;
    emit = 0;
    e = '{valid: 0, herr: 0, realign: 0, locked: 0, off: 0, data: 0, hdr: 0};
    base = m_off + cnt;
    for (int i = 0; i < 64; i++) d[i] = b[base + i];
    h = {b[base + 65], b[base + 64]};
    good = (h == 2'b01) || (h == 2'b10);
    if (dv) begin
      if (m_mode == 0) begin
        if (syn && pos <= MAX_POS) begin
          m_off = pos; m_good = 0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (good) begin
          m_good++;
          if (m_good == LOCK_GOOD) begin m_mode = 2; m_errs = 0; m_blk = 0; end
        end else begin
          emit = 1; e.herr = 1; e.realign = 1; m_mode = 0;
        end
      end else begin
        emit = 1; e.valid = 1; e.data = d; e.hdr = h;
        if (!good) begin e.herr = 1; m_errs++; end
        if (m_errs == ERR_MAX) begin
          e.realign = 1; m_mode = 0;
        end else begin
          m_blk++;
          if (m_blk == WIN_LEN) begin m_blk = 0; m_errs = 0; end
        end
      end
    end
    if (emit) begin
      e.locked = (m_mode == 2);
      e.off = 7'(m_off);
      evq.push_back(e);
    end
  endtask

  // hm: 0 = random header bits, 1 = force a good header, 2 = force a bad header.
  task automatic cyc(input bit dv, input bit syn, input int pos, input int cnt, input int hm);
    logic [223:0] w;
    logic [193:0] b;
    int base;
    for (int i = 0; i < 7; i++) w[i*32 +: 32] = $urandom;
    b = w[193:0];
    base = m_off + cnt;
    if (hm == 1) begin
      b[base + 64] = $urandom_range(1); b[base + 65] = ~b[base + 64];
    end else if (hm == 2) begin
      b[base + 64] = $urandom_range(1); b[base + 65] = b[base + 64];
    end
    bus.buffer_dv   = dv;
    bus.is_synced   = syn;
    bus.offset_pos  = 7'(pos);
    bus.gbox_cnt    = 6'(cnt);
    bus.gbox_buffer = b;
    model_step(dv, syn, pos, b, cnt);
    @(posedge clk); #1;
    chk("locked_o", 64'(bus.locked_o), 64'(m_mode == 2));
    chk("lock_offset_o", 64'(bus.lock_offset_o), 64'(m_off));
  endtask

  task automatic gap();
    if ($urandom_range(3) == 0)
      cyc(0, 1'($urandom_range(1)), $urandom_range(70), $urandom_range(63), 0);
  endtask

  task automatic lock_at(input int pos);
    cyc(1, 1, pos, $urandom_range(63), 0);
    for (int i = 0; i < LOCK_GOOD; i++) begin
      gap();
      cyc(1, 0, 0, $urandom_range(63), 1);
    end
  endtask

  task automatic drop_lock();
    for (int i = 0; i < 2 * ERR_MAX && m_mode == 2; i++) cyc(1, 0, 0, $urandom_range(63), 2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_o"}, bus.data_o, 64'd0);
    chk({tag, "_hdr_o"}, 64'(bus.hdr_o), 64'd0);
    chk({tag, "_data_valid_o"}, 64'(bus.data_valid_o), 64'd0);
    chk({tag, "_locked_o"}, 64'(bus.locked_o), 64'd0);
    chk({tag, "_lock_offset_o"}, 64'(bus.lock_offset_o), 64'd0);
    chk({tag, "_hdr_err_o"}, 64'(bus.hdr_err_o), 64'd0);
    chk({tag, "_realign_o"}, 64'(bus.realign_o), 64'd0);
  endtask

  // Monitor: every output pulse must match the next predicted event.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (bus.data_valid_o || bus.hdr_err_o || bus.realign_o)) begin
      if (evq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL spurious_event: valid=%0b herr=%0b realign=%0b, expected no event",
                 bus.data_valid_o, bus.hdr_err_o, bus.realign_o);
      end else begin
        e = evq.pop_front();
        chk("ev_data_valid_o", 64'(bus.data_valid_o), 64'(e.valid));
        chk("ev_hdr_err_o", 64'(bus.hdr_err_o), 64'(e.herr));
        chk("ev_realign_o", 64'(bus.realign_o), 64'(e.realign));
        chk("ev_locked_o", 64'(bus.locked_o), 64'(e.locked));
        chk("ev_lock_offset_o", 64'(bus.lock_offset_o), 64'(e.off));
        if (e.valid) begin
          chk("ev_data_o", bus.data_o, e.data);
          chk("ev_hdr_o", 64'(bus.hdr_o), 64'(e.hdr));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bus.buffer_dv = 0; bus.is_synced = 0; bus.offset_pos = 0;
    bus.gbox_cnt = 0; bus.gbox_buffer = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Lock at offset 17, then stream blocks.
    lock_at(17);
    for (int i = 0; i < 10; i++) begin gap(); cyc(1, 0, 0, $urandom_range(63), 1); end

    // Seven bad headers spread in a window keep lock; the eighth drops it.
    for (int k = 0; k < 40; k++) cyc(1, 0, 0, $urandom_range(63), (k % 5 == 4) ? 2 : 1);
    drop_lock();

    // Bad fifth header in VERIFY goes straight back to HUNT.
    cyc(1, 1, $urandom_range(MAX_POS), $urandom_range(63), 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, $urandom_range(63), 1);
    cyc(1, 0, 0, $urandom_range(63), 2);
    cyc(1, 1, 33, $urandom_range(63), 0);
    drop_lock();
    for (int i = 0; i < 3 && m_mode == 1; i++) cyc(1, 0, 0, $urandom_range(63), 2);

    // Seven errors per window over three windows, one landing on the final block.
    lock_at($urandom_range(MAX_POS));
    for (int wdx = 0; wdx < 3; wdx++)
      for (int k = 0; k < WIN_LEN; k++) begin
        bit bad;
        if (wdx == 0) bad = (k % 5 == 0) && k > 0 && k <= 35;
        else if (wdx == 1) bad = (k >= 1 && k <= 6) || k == 63;
        else bad = k < 7;
        gap();
        cyc(1, 0, 0, $urandom_range(63), bad ? 2 : 1);
      end
    drop_lock();

    // Out-of-range seeker offset is ignored; top-of-buffer extraction at base 128.
    cyc(1, 1, 70, $urandom_range(63), 0);
    cyc(1, 1, 127, $urandom_range(63), 0);
    cyc(1, 1, MAX_POS, 63, 0);
    for (int i = 0; i < LOCK_GOOD; i++) cyc(1, 0, 0, 63, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 63, (i == 2) ? 2 : 1);
    drop_lock();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      cyc(1'($urandom_range(3) != 0), 1'($urandom_range(1)), $urandom_range(70),
          $urandom_range(63), (r < 3) ? 2 : (r < 8) ? 0 : 1);
    end

    // Asynchronous reset between clock edges while locked.
    if (m_mode != 2) begin
      drop_lock();
      for (int i = 0; i < 3 && m_mode == 1; i++) cyc(1, 0, 0, $urandom_range(63), 2);
      lock_at(40);
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, $urandom_range(63), 1);
    @(negedge clk); #2;
    bus.buffer_dv = 0;
    rst = 1;
    #1;
    chk_all_zero("async_rst");
    m_mode = 0; m_good = 0; m_errs = 0; m_blk = 0; m_off = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk_all_zero("post_rst");
    lock_at(9);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, $urandom_range(63), 0);

    bus.buffer_dv = 0;
    repeat (3) @(posedge clk);
    #1;
    while (evq.size() > 0) begin
      ev_t e;
      e = evq.pop_front();
      vectors++; miscompares++;
      $display("FAIL missing_event: got none, expected valid=%0b herr=%0b realign=%0b",
               e.valid, e.herr, e.realign);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
